// File: rtl/cpu_pkg.sv
// Shared core constants and the clear-engine state encoding used by the register file.
package cpu_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_ADDR_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero-register masking, write-through bypass and busy masking.
module regfile_rd_port
    import cpu_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              arr_busy,
    input  logic              byp_en,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    output logic [DATA_W-1:0] rd,
    output logic              rd_busy
);

    logic hit0;
    logic hit1;

    always_comb begin
        hit1    = (BYPASS != 0) && byp_en && we1 && (wa1 == ra);
        hit0    = (BYPASS != 0) && byp_en && we0 && (wa0 == ra);
        rd      = arr_data;
        rd_busy = arr_busy && !(hit0 || hit1);
        // Port 1 wins the bypass, matching its priority on the storage write.
        if (hit1) begin
            rd = wd1;
        end else if (hit0) begin
            rd = wd0;
        end
        if ((ZERO_REG != 0) && (ra == '0)) begin
            rd      = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports, busy scoreboard
// and a sequential one-entry-per-cycle clear engine.
module regfile_mp
    import cpu_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     set_busy,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;

    logic idle;
    logic we0_eff, we1_eff, set_eff;

    // Writes and busy-sets are only honoured while idle; entry 0 may be hardwired.
    always_comb begin
        idle    = (state_q == IDLE);
        we0_eff = idle && we0 && !((ZERO_REG != 0) && (wa0 == '0));
        we1_eff = idle && we1 && !((ZERO_REG != 0) && (wa1 == '0));
        set_eff = idle && set_busy && !((ZERO_REG != 0) && (set_addr == '0));
    end

    always_comb begin
        mem_d   = mem_q;
        busy_d  = busy_q;
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        if (state_q == CLEAR) begin
            mem_d[ptr_q]  = '0;
            busy_d[ptr_q] = 1'b0;
            ptr_d         = ptr_q + ADDR_W'(1);
            if (ptr_q == '1) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else begin
            if (we0_eff) begin
                mem_d[wa0]  = wd0;
                busy_d[wa0] = 1'b0;
            end
            if (we1_eff) begin
                mem_d[wa1]  = wd1;
                busy_d[wa1] = 1'b0;
            end
            // A new producer outranks the write retiring the old one.
            if (set_eff) begin
                busy_d[set_addr] = 1'b1;
            end
            if (clr_req) begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q  <= '0;
            state_q <= IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            busy_q  <= busy_d;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    assign clr_busy = (state_q == CLEAR);
    assign clr_done = done_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_k;
        assign ra_k = ra[k*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_rd (
            .ra      (ra_k),
            .arr_data(mem_q[ra_k]),
            .arr_busy(busy_q[ra_k]),
            .byp_en  (idle),
            .we0     (we0_eff),
            .wa0     (wa0),
            .wd0     (wd0),
            .we1     (we1_eff),
            .wa1     (wa1),
            .wd1     (wd1),
            .rd      (rd[k*DATA_W +: DATA_W]),
            .rd_busy (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Vector table plus scoreboard for regfile_mp, with hand sequences for the clear engine.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           we0, we1, set_busy, clr_req;
    logic [AW-1:0]  wa0, wa1, set_addr;
    logic [DW-1:0]  wd0, wd1;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]  rd_busy;
    logic           clr_busy, clr_done;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset(reset),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd), .rd_busy(rd_busy),
        .set_busy(set_busy), .set_addr(set_addr),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          sb;
        logic [AW-1:0] sa;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] e_rd0;
        logic [DW-1:0] e_rd1;
        logic          e_bz0;
        logic          e_bz1;
    } vec_t;

    typedef struct {
        string         tag;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        logic          bz0;
        logic          bz1;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we0 = 0; wa0 = '0; wd0 = '0;
        we1 = 0; wa1 = '0; wd1 = '0;
        set_busy = 0; set_addr = '0; clr_req = 0;
    endtask

    task automatic add(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic s, input logic [AW-1:0] sa,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                       input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                       input logic b0, input logic b1);
        vec_t v;
        v.we0 = w0; v.wa0 = a0; v.wd0 = d0; v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
        v.sb = s; v.sa = sa; v.ra0 = r0; v.ra1 = r1;
        v.e_rd0 = x0; v.e_rd1 = x1; v.e_bz0 = b0; v.e_bz1 = b1;
        vecs.push_back(v);
    endtask

    task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        ra[AW-1:0] = a;
        #1;
        chk(name, rd[DW-1:0], exp);
    endtask

    initial begin
        int cnt, dn, cyc, fall_seen;
        exp_t e;
        idle_inputs();
        ra    = '0;
        reset = 1'b0;
        #1;
        chk("reset_clr_busy", {31'b0, clr_busy}, 32'd0);
        chk("reset_clr_done", {31'b0, clr_done}, 32'd0);
        #12 reset = 1'b1;

        //   we0 wa0 wd0            we1 wa1 wd1      sb sa ra0 ra1 exp_rd0       exp_rd1       bz0 bz1
        add(0, 0, 0,              0, 0, 0,         0, 0, 5, 5, 0,            0,            0, 0);
        add(1, 5, 32'hDEADBEEF,   0, 0, 0,         0, 0, 5, 7, 32'hDEADBEEF, 0,            0, 0);
        add(0, 0, 0,              0, 0, 0,         0, 0, 7, 5, 0,            32'hDEADBEEF, 0, 0);
        add(1, 9, 32'h11,         1, 9, 32'h22,    0, 0, 9, 9, 32'h22,       32'h22,       0, 0);
        add(0, 0, 0,              0, 0, 0,         0, 0, 9, 5, 32'h22,       32'hDEADBEEF, 0, 0);
        add(1, 0, 32'h1234,       0, 0, 0,         0, 0, 0, 0, 0,            0,            0, 0);
        add(0, 0, 0,              0, 0, 0,         1, 0, 0, 0, 0,            0,            0, 0);
        add(0, 0, 0,              0, 0, 0,         0, 0, 0, 9, 0,            32'h22,       0, 0);
        add(0, 0, 0,              0, 0, 0,         1, 3, 3, 0, 0,            0,            0, 0);
        add(0, 0, 0,              0, 0, 0,         0, 0, 3, 3, 0,            0,            1, 1);
        add(0, 0, 0,              1, 3, 32'h7,     0, 0, 3, 9, 32'h7,        32'h22,       0, 0);
        add(0, 0, 0,              0, 0, 0,         0, 0, 3, 3, 32'h7,        32'h7,        0, 0);
        add(1, 3, 32'h8,          0, 0, 0,         1, 3, 3, 5, 32'h8,        32'hDEADBEEF, 0, 0);
        add(0, 0, 0,              0, 0, 0,         0, 0, 3, 3, 32'h8,        32'h8,        1, 1);
        add(1, 4, 32'hAA,         1, 6, 32'hBB,    0, 0, 4, 6, 32'hAA,       32'hBB,       0, 0);
        add(0, 0, 0,              0, 0, 0,         0, 0, 4, 6, 32'hAA,       32'hBB,       0, 0);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
            we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
            set_busy = vecs[i].sb; set_addr = vecs[i].sa;
            ra = {vecs[i].ra1, vecs[i].ra0};
            e.tag = $sformatf("vec%0d", i);
            e.rd0 = vecs[i].e_rd0; e.rd1 = vecs[i].e_rd1;
            e.bz0 = vecs[i].e_bz0; e.bz1 = vecs[i].e_bz1;
            sb_q.push_back(e);
            @(negedge clk);
            e = sb_q.pop_front();
            chk({e.tag, "_rd0"}, rd[DW-1:0], e.rd0);
            chk({e.tag, "_rd1"}, rd[2*DW-1:DW], e.rd1);
            chk({e.tag, "_bz0"}, {31'b0, rd_busy[0]}, {31'b0, e.bz0});
            chk({e.tag, "_bz1"}, {31'b0, rd_busy[1]}, {31'b0, e.bz1});
        end
        @(posedge clk); #1;
        idle_inputs();

        // Fill every entry, then run a full clear while hammering writes.
        for (int i = 1; i < 32; i++) begin
            we0 = 1; wa0 = AW'(i); wd0 = 32'h1000 + i;
            @(posedge clk); #1;
        end
        idle_inputs();
        rd_chk("fill_r31", 5'd31, 32'h101F);
        clr_req = 1;
        @(posedge clk); #1;
        clr_req = 0;
        we0 = 1; wa0 = 7; wd0 = 32'hFFFF;
        we1 = 1; wa1 = 9; wd1 = 32'hEEEE;
        set_busy = 1; set_addr = 8;
        ra = {5'd8, 5'd7};
        #1;
        chk("clr_no_bypass", rd[DW-1:0], 32'h1007);
        chk("clr_no_busy", {31'b0, rd_busy[1]}, 32'd0);
        cnt = 0; dn = 0; fall_seen = 0;
        for (cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (clr_busy) cnt++;
            if (clr_done) dn++;
            if (!clr_busy && fall_seen == 0) begin
                fall_seen = 1;
                chk("done_after_last", {31'b0, clr_done}, 32'd1);
                idle_inputs();
            end
            if (fall_seen != 0 && !clr_busy && cyc > 40) break;
        end
        chk("clr_cycles", cnt, 32);
        chk("clr_done_pulses", dn, 1);
        for (int i = 0; i < 32; i++) begin
            ra = {AW'(i), AW'(i)};
            #1;
            chk($sformatf("cleared_r%0d", i), rd[DW-1:0], 32'd0);
            chk($sformatf("cleared_bz%0d", i), {31'b0, rd_busy[0]}, 32'd0);
        end

        // Reset in the middle of a clear.
        @(posedge clk); #1;
        we0 = 1; wa0 = 5; wd0 = 32'h55;
        @(posedge clk); #1;
        idle_inputs();
        clr_req = 1;
        @(posedge clk); #1;
        clr_req = 0;
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_abort_busy", {31'b0, clr_busy}, 32'd0);
        chk("rst_abort_done", {31'b0, clr_done}, 32'd0);
        rd_chk("rst_r5", 5'd5, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        dn = 0;
        repeat (4) begin
            @(negedge clk);
            if (clr_done) dn++;
        end
        chk("rst_no_done", dn, 0);

        @(posedge clk); #1;
        we0 = 1; wa0 = 1; wd0 = 32'hA;
        we1 = 1; wa1 = 31; wd1 = 32'hB;
        @(posedge clk); #1;
        idle_inputs();
        clr_req = 1;
        ra = {5'd31, 5'd1};
        @(posedge clk); #1;
        clr_req = 0;
        @(negedge clk);
        chk("restart_r1_c0", rd[DW-1:0], 32'hA);
        @(negedge clk);
        chk("restart_r1_c1", rd[DW-1:0], 32'hA);
        @(negedge clk);
        chk("restart_r1_c2", rd[DW-1:0], 32'd0);
        chk("restart_r31", rd[2*DW-1:DW], 32'hB);
        cnt = 3;
        for (cyc = 0; cyc < 100 && clr_busy; cyc++) begin
            @(negedge clk);
            if (clr_busy) cnt++;
        end
        chk("restart_cycles", cnt, 32);
        chk("restart_r31_end", rd[2*DW-1:DW], 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
